decoder_scan: RTL and testbench



---
 rtl/decoder_pkg.sv | 15 +
 rtl/onehot_dec.sv | 19 +
 rtl/decoder_scan.sv | 100 ++++++++++
 tb/tb_decoder_scan.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning one-hot decoder: mode encoding and
// default widths.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } decode_mode_e;

    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable; generalised form of
// the fixed 3-to-8 decoder. Output is all-zero when en is low.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y
);

    // Set exactly one bit, chosen by sel, when enabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct select, auto-scan
// up/down with programmable dwell, hold, and a wrap pulse at end of range.
// Every output comes straight from a register; the next-state logic below
// computes the next index and the one-hot decode of that next index.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] Y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    decode_mode_e       mode_e;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic               wrap_nxt;
    logic               y_en;
    logic [OUT_W-1:0]   y_nxt;

    assign mode_e = decode_mode_e'(mode);

    // Next index, dwell count and wrap flag for the coming edge.
    // The dwell compare uses >= against the live dwell input so that a
    // lowered dwell takes effect immediately and cnt can never run away.
    always_comb begin
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        y_en     = 1'b1;
        if (!en) begin
            y_en    = 1'b0;
            cnt_nxt = '0;
        end else begin
            case (mode_e)
                MODE_DIRECT: begin
                    idx_nxt = sel;
                    cnt_nxt = '0;
                end
                MODE_SCAN_UP: begin
                    if (cnt >= dwell) begin
                        idx_nxt  = idx + SEL_W'(1);
                        cnt_nxt  = '0;
                        wrap_nxt = (idx == IDX_LAST);
                    end else begin
                        cnt_nxt = cnt + DWELL_W'(1);
                    end
                end
                MODE_SCAN_DOWN: begin
                    if (cnt >= dwell) begin
                        idx_nxt  = idx - SEL_W'(1);
                        cnt_nxt  = '0;
                        wrap_nxt = (idx == '0);
                    end else begin
                        cnt_nxt = cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    // MODE_HOLD: index and count frozen, output still driven
                end
            endcase
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (y_en),
        .sel (idx_nxt),
        .y   (y_nxt)
    );

    // Output and state registers; reset restarts the scan at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y    <= '0;
            idx  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            Y    <= y_nxt;
            idx  <= idx_nxt;
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed testbench for decoder_scan (SEL_W=3, DWELL_W=8) with a queue
// scoreboard of expected Y/idx/wrap per clock.
module tb_decoder_scan;
    import decoder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic [7:0] Y;
    logic [2:0] idx;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
        string      tag;
    } exp_t;

    exp_t sb[$];

    decoder_scan #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .dwell (dwell),
        .Y     (Y),
        .idx   (idx),
        .wrap  (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pop the oldest expectation and compare it with the outputs.
    task automatic check_out();
        exp_t x;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=nonzero", sb.size());
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            checks++;
            assert (Y === x.y) else begin
                errors++;
                $error("FAIL %s.Y observed=%h expected=%h", x.tag, Y, x.y);
            end
            checks++;
            assert (idx === x.idx) else begin
                errors++;
                $error("FAIL %s.idx observed=%0d expected=%0d", x.tag, idx, x.idx);
            end
            checks++;
            assert (wrap === x.wrap) else begin
                errors++;
                $error("FAIL %s.wrap observed=%b expected=%b", x.tag, wrap, x.wrap);
            end
        end
    endtask

    // Drive one cycle of inputs, record what must appear after the edge,
    // then sample just after that edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [2:0] s, input logic [7:0] d,
                        input logic [7:0] ey, input logic [2:0] ei,
                        input logic ew, input string tag);
        exp_t x;
        rst_n = r;
        en    = e;
        mode  = m;
        sel   = s;
        dwell = d;
        x.y    = ey;
        x.idx  = ei;
        x.wrap = ew;
        x.tag  = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = MODE_DIRECT;
        sel   = 3'd5;
        dwell = 8'd0;

        // Reset held two cycles with DIRECT sel=5 pending
        step(0, 1, MODE_DIRECT, 3'd5, 8'd0, 8'h00, 3'd0, 0, "reset0");
        step(0, 1, MODE_DIRECT, 3'd5, 8'd0, 8'h00, 3'd0, 0, "reset1");
        step(1, 1, MODE_DIRECT, 3'd5, 8'd0, 8'h20, 3'd5, 0, "rel");

        // DIRECT sweep, one cycle latency
        for (int i = 0; i < 8; i++) begin
            step(1, 1, MODE_DIRECT, 3'(i), 8'd0, 8'(1 << i), 3'(i), 0, "direct");
        end
        step(1, 0, MODE_DIRECT, 3'd7, 8'd0, 8'h00, 3'd7, 0, "en_off");

        // SCAN_UP dwell=2 from idx 6, wraps 7->0
        step(1, 1, MODE_DIRECT,  3'd6, 8'd2, 8'h40, 3'd6, 0, "up_load");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h40, 3'd6, 0, "up_a");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h40, 3'd6, 0, "up_b");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h80, 3'd7, 0, "up_c");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h80, 3'd7, 0, "up_d");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h80, 3'd7, 0, "up_e");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h01, 3'd0, 1, "up_wrap");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h01, 3'd0, 0, "up_f");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h01, 3'd0, 0, "up_g");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h02, 3'd1, 0, "up_h");

        // SCAN_DOWN dwell=0 from idx 1, wraps 0->7
        step(1, 1, MODE_DIRECT,    3'd1, 8'd0, 8'h02, 3'd1, 0, "dn_load");
        step(1, 1, MODE_SCAN_DOWN, 3'd0, 8'd0, 8'h01, 3'd0, 0, "dn_a");
        step(1, 1, MODE_SCAN_DOWN, 3'd0, 8'd0, 8'h80, 3'd7, 1, "dn_wrap");
        step(1, 1, MODE_SCAN_DOWN, 3'd0, 8'd0, 8'h40, 3'd6, 0, "dn_b");

        // HOLD mid-dwell keeps cnt
        step(1, 1, MODE_DIRECT,  3'd3, 8'd3, 8'h08, 3'd3, 0, "hold_load");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd3, 8'h08, 3'd3, 0, "hold_up1");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd3, 8'h08, 3'd3, 0, "hold_up2");
        for (int i = 0; i < 5; i++) begin
            step(1, 1, MODE_HOLD, 3'd0, 8'd3, 8'h08, 3'd3, 0, "hold");
        end
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd3, 8'h08, 3'd3, 0, "hold_res1");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd3, 8'h10, 3'd4, 0, "hold_res2");

        // Dwell lowered below cnt advances on next edge
        step(1, 1, MODE_DIRECT, 3'd2, 8'd10, 8'h04, 3'd2, 0, "dw_load");
        for (int i = 0; i < 5; i++) begin
            step(1, 1, MODE_SCAN_UP, 3'd0, 8'd10, 8'h04, 3'd2, 0, "dw_cnt");
        end
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd1, 8'h08, 3'd3, 0, "dw_drop");

        // Reset with wrap pending (idx=7, cnt=dwell)
        step(1, 1, MODE_DIRECT,  3'd7, 8'd2, 8'h80, 3'd7, 0, "rw_load");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h80, 3'd7, 0, "rw_1");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h80, 3'd7, 0, "rw_2");
        step(0, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h00, 3'd0, 0, "rw_rst");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd2, 8'h01, 3'd0, 0, "rw_rel");

        // en=0 mid-scan clears cnt; resume with dwell=0 advances at once
        step(1, 0, MODE_SCAN_UP, 3'd0, 8'd0, 8'h00, 3'd0, 0, "en_mid");
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'd0, 8'h02, 3'd1, 0, "en_res");

        // Maximum dwell: each index shown 256 cycles
        step(1, 1, MODE_DIRECT, 3'd0, 8'hFF, 8'h01, 3'd0, 0, "max_load");
        for (int i = 0; i < 255; i++) begin
            step(1, 1, MODE_SCAN_UP, 3'd0, 8'hFF, 8'h01, 3'd0, 0, "max_dw");
        end
        step(1, 1, MODE_SCAN_UP, 3'd0, 8'hFF, 8'h02, 3'd1, 0, "max_adv");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
